// File: rtl/audio_volume_scaler.sv
// audio_volume_scaler
//   Per-channel dB attenuation and mute for 16-bit stereo samples. Each
//   accepted sample first ramps the current attenuation one bounded step
//   toward its target, then scales L and R with a serial shift-add
//   multiplier (one partial product per cycle, 16 cycles per channel).
//
// Ports
//   mon_clk      in   sole clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   1-cycle strobe, in_data holds a new sample
//   in_data      in   [31:16]=L, [15:0]=R, signed
//   db_val_valid in   1-cycle strobe, lch_db/rch_db/is_muted valid
//   lch_db       in   left target attenuation, dB (0..63)
//   rch_db       in   right target attenuation, dB (0..63)
//   is_muted     in   mute request
//   out_valid    out  1-cycle strobe, out_data holds the scaled sample
//   out_data     out  scaled sample, same packing as in_data
//   busy         out  high while a sample is in flight
//   overrun      out  1-cycle pulse, in_valid arrived while busy (dropped)
module audio_volume_scaler #(
    parameter int unsigned MUTE_DB   = 60,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic        mon_clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        db_val_valid,
    input  logic [5:0]  lch_db,
    input  logic [5:0]  rch_db,
    input  logic        is_muted,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_MUL_L,
        S_MUL_R,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        sample_q, sample_d;
    logic [5:0]         tgt_l_q, tgt_l_d;
    logic [5:0]         tgt_r_q, tgt_r_d;
    logic [5:0]         cur_l_q, cur_l_d;
    logic [5:0]         cur_r_q, cur_r_d;
    logic               mute_q, mute_d;
    logic [3:0]         cnt_q, cnt_d;
    logic signed [32:0] acc_q, acc_d;
    logic [15:0]        y_l_q, y_l_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               overrun_q, overrun_d;

    // Datapath for the channel currently being multiplied
    logic [5:0]         cur_sel;
    logic [5:0]         gain_q;
    logic [5:0]         gain_r;
    logic [5:0]         shamt;
    logic [15:0]        mant;
    logic [15:0]        s;
    logic signed [32:0] s_ext;
    logic signed [32:0] pp;
    logic signed [32:0] prod;
    logic [15:0]        y;
    logic               zero_out;

    function automatic logic [15:0] mant_lut(input logic [5:0] r);
        logic [15:0] m;
        case (r)
            6'd0:    m = 16'd32768;
            6'd1:    m = 16'd29205;
            6'd2:    m = 16'd26029;
            6'd3:    m = 16'd23198;
            6'd4:    m = 16'd20675;
            6'd5:    m = 16'd18427;
            default: m = 16'd32768;
        endcase
        return m;
    endfunction

    // Move cur toward tgt by at most RAMP_STEP dB
    function automatic logic [5:0] ramp(input logic [5:0] cur, input logic [5:0] tgt);
        logic [6:0] diff;
        logic [6:0] step;
        logic [5:0] nxt;
        if (tgt > cur) diff = 7'(tgt) - 7'(cur);
        else           diff = 7'(cur) - 7'(tgt);
        step = (32'(diff) > RAMP_STEP) ? 7'(RAMP_STEP) : diff;
        if (tgt > cur) nxt = cur + step[5:0];
        else           nxt = cur - step[5:0];
        return nxt;
    endfunction

    always_comb begin
        cur_sel  = (state_q == S_MUL_L) ? cur_l_q : cur_r_q;
        gain_q   = cur_sel / 6'd6;
        gain_r   = cur_sel % 6'd6;
        shamt    = 6'd15 + gain_q;
        mant     = mant_lut(gain_r);
        s        = (state_q == S_MUL_L) ? sample_q[31:16] : sample_q[15:0];
        s_ext    = {{17{s[15]}}, s};
        // Mantissa is the unsigned multiplier, so each set bit adds the
        // sign-extended sample shifted into place; after 16 bits acc holds s*MANT.
        pp       = mant[cnt_q] ? (s_ext <<< cnt_q) : '0;
        prod     = acc_q + pp;
        zero_out = (32'(cur_sel) >= MUTE_DB);
        y        = zero_out ? '0 : 16'(prod >>> shamt);
    end

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        tgt_l_d    = tgt_l_q;
        tgt_r_d    = tgt_r_q;
        cur_l_d    = cur_l_q;
        cur_r_d    = cur_r_q;
        mute_d     = mute_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        y_l_d      = y_l_q;
        out_data_d = out_data_q;
        overrun_d  = 1'b0;

        if (db_val_valid) begin
            tgt_l_d = lch_db;
            tgt_r_d = rch_db;
            mute_d  = is_muted;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (in_valid) begin
                    sample_d = in_data;
                    state_d  = S_RAMP;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RAMP: begin
                overrun_d = in_valid;
                cur_l_d   = ramp(cur_l_q, tgt_l_q);
                cur_r_d   = ramp(cur_r_q, tgt_r_q);
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = S_MUL_L;
            end
            S_MUL_L: begin
                overrun_d = in_valid;
                acc_d     = prod;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    y_l_d   = y;
                    acc_d   = '0;
                    state_d = S_MUL_R;
                end
            end
            S_MUL_R: begin
                overrun_d = in_valid;
                acc_d     = prod;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    // Mute is applied to both channels together at output time
                    out_data_d = mute_q ? '0 : {y_l_q, y};
                    acc_d      = '0;
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sample_q   <= '0;
            tgt_l_q    <= '0;
            tgt_r_q    <= '0;
            cur_l_q    <= '0;
            cur_r_q    <= '0;
            mute_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            y_l_q      <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            tgt_l_q    <= tgt_l_d;
            tgt_r_q    <= tgt_r_d;
            cur_l_q    <= cur_l_d;
            cur_r_q    <= cur_r_d;
            mute_q     <= mute_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            y_l_q      <= y_l_d;
            out_data_q <= out_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RAMP) || (state_q == S_MUL_L) || (state_q == S_MUL_R);
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_volume_scaler.sv
// tb_audio_volume_scaler
//   Directed-vector bench for audio_volume_scaler: a table of settings and
//   samples with hand-computed or reference-model expected outputs, plus
//   sequences for latency, ramp, mute threshold, overrun and mid-sample reset.
`timescale 1ns/1ps
module tb_audio_volume_scaler;

    logic        mon_clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        db_val_valid = 1'b0;
    logic [5:0]  lch_db = '0;
    logic [5:0]  rch_db = '0;
    logic        is_muted = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    audio_volume_scaler #(.MUTE_DB(60), .RAMP_STEP(1)) dut (
        .mon_clk      (mon_clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .db_val_valid (db_val_valid),
        .lch_db       (lch_db),
        .rch_db       (rch_db),
        .is_muted     (is_muted),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #100 mon_clk = ~mon_clk;

    typedef struct {
        logic        set;
        logic [5:0]  ldb;
        logic [5:0]  rdb;
        logic        mute;
        logic [31:0] din;
        int          cur_l;
        int          cur_r;
        logic        use_model;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    // Direct-multiply reference for one channel
    function automatic logic [15:0] gain_ref(input logic [15:0] smp, input int cur);
        int     mant[6];
        longint p;
        mant = '{32768, 29205, 26029, 23198, 20675, 18427};
        if (cur >= 60) return 16'h0000;
        p = longint'($signed(smp)) * longint'(mant[cur % 6]);
        p = p >>> (15 + cur / 6);
        return p[15:0];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] din, input int cl, input int cr);
        return {gain_ref(din[31:16], cl), gain_ref(din[15:0], cr)};
    endfunction

    task automatic tick();
        @(posedge mon_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_db(input logic [5:0] l, input logic [5:0] r, input logic m);
        db_val_valid = 1'b1;
        lch_db = l;
        rch_db = r;
        is_muted = m;
        tick();
        db_val_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns ticks waited after the accepting edge; -1 on timeout
    task automatic wait_out(output logic [31:0] d, output int n);
        n = -1;
        d = '0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (out_valid) begin
                n = i;
                d = out_data;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got none expected out_valid within 100 cycles");
        end
    endtask

    initial begin
        logic [31:0] d;
        int          n;
        int          cnt;

        do_reset();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_overrun", {31'b0, overrun}, 32'd0);

        // Unity gain and exact latency
        send(32'h4000C000);
        chk("busy_in_ramp", {31'b0, busy}, 32'd1);
        wait_out(d, n);
        chk("latency", 32'(n + 1), 32'd34);
        chk("unity_data", d, 32'h4000C000);
        chk("busy_in_done", {31'b0, busy}, 32'd0);

        // set, ldb, rdb, mute, din, cur_l, cur_r, use_model, exp
        vecs[0]  = '{1'b1, 6'd6, 6'd6, 1'b0, 32'h4000C000, 1, 1, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 6'd6, 6'd6, 1'b0, 32'h4000C000, 2, 2, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 6'd6, 6'd6, 1'b0, 32'h4000C000, 3, 3, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 6'd6, 6'd6, 1'b0, 32'h4000C000, 4, 4, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 6'd6, 6'd6, 1'b0, 32'h4000C000, 5, 5, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 6'd6, 6'd6, 1'b0, 32'h4000C000, 6, 6, 1'b0, 32'h2000E000};
        vecs[6]  = '{1'b0, 6'd6, 6'd6, 1'b0, 32'h4000C000, 6, 6, 1'b0, 32'h2000E000};
        vecs[7]  = '{1'b1, 6'd1, 6'd1, 1'b0, 32'h7FFF8000, 5, 5, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 6'd1, 6'd1, 1'b0, 32'h7FFF8000, 4, 4, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 6'd1, 6'd1, 1'b0, 32'h7FFF8000, 3, 3, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 6'd1, 6'd1, 1'b0, 32'h7FFF8000, 2, 2, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 6'd1, 6'd1, 1'b0, 32'h7FFF8000, 1, 1, 1'b0, 32'h72148DEB};
        vecs[12] = '{1'b1, 6'd1, 6'd1, 1'b1, 32'h7FFF8000, 1, 1, 1'b0, 32'h00000000};
        vecs[13] = '{1'b1, 6'd1, 6'd1, 1'b0, 32'h7FFF8000, 1, 1, 1'b0, 32'h72148DEB};
        vecs[14] = '{1'b1, 6'd0, 6'd1, 1'b0, 32'h4000C000, 0, 1, 1'b0, 32'h4000C6F5};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].set) set_db(vecs[i].ldb, vecs[i].rdb, vecs[i].mute);
            send(vecs[i].din);
            wait_out(d, n);
            chk($sformatf("vec%0d", i), d,
                vecs[i].use_model ? model(vecs[i].din, vecs[i].cur_l, vecs[i].cur_r)
                                  : vecs[i].exp);
        end

        // Settings and sample on the same cycle: new target used in this ramp
        do_reset();
        db_val_valid = 1'b1;
        lch_db = 6'd6;
        rch_db = 6'd6;
        is_muted = 1'b0;
        send(32'h4000C000);
        db_val_valid = 1'b0;
        wait_out(d, n);
        chk("simultaneous_db", d, 32'h390AC6F5);

        // Ramp 0 -> 10, one dB per sample
        do_reset();
        set_db(6'd10, 6'd10, 1'b0);
        for (int i = 0; i < 12; i++) begin
            send(32'h7FFF7FFF);
            wait_out(d, n);
            chk($sformatf("ramp%0d", i), d,
                model(32'h7FFF7FFF, (i + 1 > 10) ? 10 : i + 1, (i + 1 > 10) ? 10 : i + 1));
        end

        // Mute threshold: cur 59 passes, cur 60 forced to zero
        do_reset();
        set_db(6'd63, 6'd63, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            send(32'h7FFF7FFF);
            wait_out(d, n);
            if (k == 59) chk("cur59", d, 32'h00230023);
            if (k == 60) chk("cur60_zero", d, 32'h00000000);
        end

        // Overrun: second in_valid 5 cycles after the first
        do_reset();
        send(32'h4000C000);
        for (int i = 0; i < 4; i++) tick();
        send(32'h12345678);
        chk("overrun_pulse", {31'b0, overrun}, 32'd1);
        tick();
        chk("overrun_clear", {31'b0, overrun}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                cnt++;
                chk("overrun_kept_first", out_data, 32'h4000C000);
            end
            tick();
        end
        chk("overrun_one_output", 32'(cnt), 32'd1);

        // Reset in cycle 20 of a sample aborts it and clears settings
        set_db(6'd10, 6'd10, 1'b0);
        send(32'h7FFF7FFF);
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("abort_no_output", 32'(cnt), 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        send(32'h4000C000);
        wait_out(d, n);
        chk("after_abort", d, 32'h4000C000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
